fetch_unit: RTL and testbench

Parametrised instruction fetch stage. It generates sequential PCs and issues requests to an instruction memory over a valid/ready request channel with in-order responses of variable latency. Fetched instructions are buffered in a small allocate-on-request queue and delivered to decode over a valid/ready handshake. Adds branch/exception redirect with queue flush and discard of stale in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 32 +++
 rtl/fetch_queue.sv | 98 +++++++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, defaults and the fetch queue entry type.
package fetch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ILEN         = 32;
    localparam int unsigned DEF_FQ_DEPTH = 4;
    localparam int unsigned DEF_PC_STEP  = 4;
    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

    // Stale responses can pile up across back-to-back redirects, so this is
    // deliberately wider than the queue depth.
    localparam int unsigned DROP_W = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory and decode handshakes of the fetch stage.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instruction;

    // Fetch stage side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_pc, if_instruction,
        input  if_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_pc, if_instruction,
        output if_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Allocate-on-request fetch queue: entries are allocated at tail, filled in
// allocation order by responses, and popped from head once filled.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned FQ_DEPTH = DEF_FQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_en,
    input  logic [XLEN-1:0]           alloc_pc,
    input  logic                      fill_en,
    input  logic [ILEN-1:0]           fill_instr,
    input  logic                      pop_en,
    input  logic                      flush,
    output logic                      head_valid_c,
    output logic [XLEN-1:0]           head_pc_c,
    output logic [ILEN-1:0]           head_instr_c,
    output logic [$clog2(FQ_DEPTH):0] count,
    output logic [$clog2(FQ_DEPTH):0] pend_count
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fq_entry_t        entries_q [FQ_DEPTH];
    fq_entry_t        entries_d [FQ_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    // Next-state for entries, pointers, occupancy and unfilled count
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        fill_d    = fill_q;
        count_d   = count_q;
        pend_d    = pend_q;

        if (flush) begin
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end else begin
            if (alloc_en) begin
                entries_d[tail_q] = '{pc: alloc_pc, instr: '0, filled: 1'b0};
                tail_d            = tail_q + PTR_W'(1);
            end
            if (fill_en) begin
                entries_d[fill_q].instr  = fill_instr;
                entries_d[fill_q].filled = 1'b1;
                fill_d                   = fill_q + PTR_W'(1);
            end
            if (pop_en) begin
                entries_d[head_q].filled = 1'b0;
                head_d                   = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(alloc_en) - CNT_W'(pop_en);
            pend_d  = pend_q + CNT_W'(alloc_en) - CNT_W'(fill_en);
        end
    end

    // Queue state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
        end
    end

    assign head_valid_c = (count_q != '0) && entries_q[head_q].filled;
    assign head_pc_c    = entries_q[head_q].pc;
    assign head_instr_c = entries_q[head_q].instr;
    assign count        = count_q;
    assign pend_count   = pend_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, request issue, redirect
// with queue flush and discard of stale in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     FQ_DEPTH = DEF_FQ_DEPTH,
    parameter int unsigned     PC_STEP  = DEF_PC_STEP,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    fetch_if.master                   bus,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              req_valid_c;
    logic              req_fire;
    logic              resp_drop;
    logic              fill_en;
    logic              pop_en;
    logic              head_valid_c;
    logic [XLEN-1:0]   head_pc_c;
    logic [ILEN-1:0]   head_instr_c;
    logic [CNT_W-1:0]  pend_count;

    // Request gating, response routing and next fetch PC / drop count
    always_comb begin
        req_valid_c = !reset && !redirect_valid && (fq_count < CNT_W'(FQ_DEPTH));
        req_fire    = req_valid_c && bus.imem_req_ready;
        resp_drop   = bus.imem_resp_valid && (drop_cnt_q != '0);
        fill_en     = bus.imem_resp_valid && (drop_cnt_q == '0);
        pop_en      = head_valid_c && bus.if_ready;

        fetch_pc_d  = fetch_pc_q;
        drop_cnt_d  = drop_cnt_q - DROP_W'(resp_drop);

        if (redirect_valid) begin
            // Every still-unfilled request becomes stale, net of this cycle's response
            fetch_pc_d = redirect_pc;
            drop_cnt_d = drop_cnt_q + DROP_W'(pend_count)
                       - DROP_W'(fill_en) - DROP_W'(resp_drop);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
    end

    // Fetch PC and stale-response counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .alloc_en     (req_fire),
        .alloc_pc     (fetch_pc_q),
        .fill_en      (fill_en),
        .fill_instr   (bus.imem_resp_data),
        .pop_en       (pop_en),
        .flush        (redirect_valid),
        .head_valid_c (head_valid_c),
        .head_pc_c    (head_pc_c),
        .head_instr_c (head_instr_c),
        .count        (fq_count),
        .pend_count   (pend_count)
    );

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.if_valid       = head_valid_c;
    assign bus.if_pc          = head_pc_c;
    assign bus.if_instruction = head_instr_c;

    // A response must always belong to an outstanding live or stale request
    assert property (@(posedge clk) disable iff (reset)
        bus.imem_resp_valid |-> ((drop_cnt_q != '0) || (pend_count != '0)))
        else $error("fetch_unit: response with no outstanding request");

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order variable-latency memory model,
// reference queue scoreboard, a startup vector table and redirect/reset cases.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  fq_count;

    fetch_if bus ();

    fetch_unit #(
        .FQ_DEPTH (4),
        .PC_STEP  (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t        memq[$];
    int          last_due;
    int          lat_min, lat_max;

    logic [31:0] mq[$];
    int          mfill;
    int          mdrop;
    logic [31:0] mpc;

    typedef struct {
        logic        req_ready;
        logic        if_ready;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
        logic        exp_if_valid;
        logic [31:0] exp_if_pc;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        mq.delete();
        memq.delete();
        mfill    = 0;
        mdrop    = 0;
        mpc      = 32'h0;
        last_due = -1;
    endtask

    // Called at the negedge: compare DUT against the reference, then advance it
    task automatic model_step();
        bit   exp_ifv, exp_rv, pop, fire, fill;
        mem_t m;
        int   lat;
        exp_ifv = (mq.size() > 0) && (mfill > 0);
        chk("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
        if (exp_ifv) begin
            chk("if_pc", bus.if_pc, mq[0]);
            chk("if_instruction", bus.if_instruction, instr_of(mq[0]));
        end
        exp_rv = !redirect_valid && (mq.size() < 4);
        chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("imem_req_addr", bus.imem_req_addr, mpc);
        chk("fq_count", 32'(fq_count), 32'(mq.size()));

        pop  = exp_ifv && bus.if_ready;
        fire = exp_rv && bus.imem_req_ready;
        fill = bus.imem_resp_valid && (mdrop == 0);
        if (bus.imem_resp_valid && mdrop > 0) mdrop--;
        if (fill) mfill++;
        if (fire) begin
            lat = $urandom_range(lat_max, lat_min);
            m.addr = mpc;
            m.due  = cyc + lat;
            if (m.due <= last_due) m.due = last_due + 1;
            last_due = m.due;
            memq.push_back(m);
        end
        if (redirect_valid) begin
            mdrop += mq.size() - mfill;
            mq.delete();
            mfill = 0;
            mpc   = redirect_pc;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                mfill--;
            end
            if (fire) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // Move to just after the next rising edge and present the memory response
    task automatic advance();
        mem_t m;
        @(posedge clk);
        #1;
        cyc++;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = instr_of(m.addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        advance();
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.if_ready        = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_fq_count", 32'(fq_count), 32'h0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Run up to n cycles; on the first if_valid check the head against exp_pc
    task automatic wait_head(input int n, input logic [31:0] exp_pc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.if_valid && !seen) begin
                seen = 1'b1;
                chk({name, "_pc"}, bus.if_pc, exp_pc);
                chk({name, "_instr"}, bus.if_instruction, instr_of(exp_pc));
                chk({name, "_drop_cnt"}, 32'(dut.drop_cnt_q), 32'h0);
            end
            model_step();
            advance();
        end
        chk({name, "_seen"}, 32'(seen), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd2};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd2};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 3'd2};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 3'd3};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 3'd2};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 3'd2};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 3'd2};

        lat_min = 1;
        lat_max = 1;

        // Startup latency and steady one-per-cycle streaming
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.imem_req_ready = vecs[i].req_ready;
            bus.if_ready       = vecs[i].if_ready;
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].exp_req_valid));
            chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_if_valid", i), 32'(bus.if_valid), 32'(vecs[i].exp_if_valid));
            if (vecs[i].exp_if_valid) chk($sformatf("vec%0d_if_pc", i), bus.if_pc, vecs[i].exp_if_pc);
            chk($sformatf("vec%0d_fq_count", i), 32'(fq_count), 32'(vecs[i].exp_count));
            model_step();
            advance();
        end

        // Decode stalled: queue fills to depth and requests stop, then drains in order
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("full_fq_count", 32'(fq_count), 32'd4);
        chk("full_req_valid", 32'(bus.imem_req_valid), 32'h0);
        model_step();
        advance();
        bus.if_ready = 1'b1;
        wait_head(12, 32'h0, "drain_head");

        // Redirect with two stale requests outstanding at latency 3
        do_reset();
        lat_min = 3;
        lat_max = 3;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        repeat (2) tick();
        bus.imem_req_ready = 1'b0;
        redirect_valid     = 1'b1;
        redirect_pc        = 32'h100;
        tick();
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        chk("stale_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        chk("stale_req_addr", bus.imem_req_addr, 32'h100);
        model_step();
        advance();
        wait_head(12, 32'h100, "stale_head");

        // Redirect coinciding with a live response and a pop
        do_reset();
        lat_min = 1;
        lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        chk("coinc_resp_valid_pre", 32'(bus.imem_resp_valid), 32'h1);
        chk("coinc_pop_if_pc", bus.if_pc, 32'h8);
        chk("coinc_req_valid", 32'(bus.imem_req_valid), 32'h0);
        model_step();
        advance();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_drop_cnt", 32'(dut.drop_cnt_q), 32'h0);
        chk("coinc_if_valid", 32'(bus.if_valid), 32'h0);
        chk("coinc_req_addr", bus.imem_req_addr, 32'h200);
        model_step();
        advance();
        wait_head(8, 32'h200, "coinc_head");

        // Random ready/stall/redirect traffic with variable latency
        do_reset();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            bus.if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid     = ($urandom_range(0, 24) == 0);
            redirect_pc        = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b1;
        repeat (20) tick();
        chk("random_mem_drained", 32'(memq.size()), 32'h0);

        // Reset with three queued entries
        do_reset();
        lat_min = 1;
        lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b0;
        repeat (3) tick();
        #1;
        chk("prerst_fq_count", 32'(fq_count), 32'd3);
        chk("prerst_if_valid", 32'(bus.if_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("midrst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("midrst_fq_count", 32'(fq_count), 32'h0);
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        @(negedge clk);
        chk("postrst_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("postrst_req_addr", bus.imem_req_addr, 32'h0);
        model_step();
        advance();
        wait_head(6, 32'h0, "postrst_head");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
